// File: rtl/bcd_display_scan_if.sv
// Bundle of the load-side inputs and scan-side outputs of the
// multiplexed eight-digit BCD display driver.
interface bcd_display_scan_if;
   logic        load;
   logic [31:0] segmentos;
   logic        neg;
   logic [7:0]  anodo;
   logic [6:0]  hex;
   logic [2:0]  digito;
   logic        frame_done;
   logic        ovf;

   modport master (
      output load, segmentos, neg,
      input  anodo, hex, digito, frame_done, ovf
   );

   modport slave (
      input  load, segmentos, neg,
      output anodo, hex, digito, frame_done, ovf
   );
endinterface

// File: rtl/bcd_display_scan.sv
// Eight-digit multiplexed BCD display scanner with leading-zero
// blanking, minus sign and tear-free frame updates.
module bcd_display_scan #(
   parameter int unsigned PRESCALE = 50000
) (
   input logic              clock,
   input logic              reset,
   bcd_display_scan_if.slave bus
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    dig_q, dig_d;
   logic          fd_q, fd_d;
   logic [31:0]   pseg_q, pseg_d;
   logic          pneg_q, pneg_d;
   logic [31:0]   aseg_q, aseg_d;
   logic          aneg_q, aneg_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    hex_q, hex_d;
   logic          ovf_q, ovf_d;

   logic          tick;
   logic          wrap;
   logic [2:0]    msd;
   logic [3:0]    nib;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h06;
      endcase
      return s;
   endfunction

   assign tick = (presc_q == PMAX);
   assign wrap = tick && (dig_q == 3'd7);

   // Dwell counter, digit index and double-buffered display data;
   // a load coinciding with the wrap bypasses the pending set.
   always_comb begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      dig_d   = tick ? dig_q + 3'd1 : dig_q;
      fd_d    = wrap;
      pseg_d  = pseg_q;
      pneg_d  = pneg_q;
      aseg_d  = aseg_q;
      aneg_d  = aneg_q;
      if (bus.load) begin
         pseg_d = bus.segmentos;
         pneg_d = bus.neg;
      end
      if (wrap) begin
         aseg_d = bus.load ? bus.segmentos : pseg_q;
         aneg_d = bus.load ? bus.neg : pneg_q;
      end
   end

   // Most significant nonzero nibble of the displayed value.
   always_comb begin
      msd = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (aseg_q[4*i +: 4] != 4'd0) msd = 3'(i);
      end
   end

   // Segment, anode and overflow decode for the digit now scanned.
   always_comb begin
      nib   = aseg_q[{dig_q, 2'b00} +: 4];
      hex_d = seg7(nib);
      an_d  = ~(8'd1 << dig_q);
      ovf_d = aneg_q && (msd == 3'd7);
      if ((dig_q != 3'd0) && (dig_q > msd)) begin
         if (aneg_q && ({1'b0, dig_q} == {1'b0, msd} + 4'd1))
            hex_d = 7'h3F;
         else
            hex_d = 7'h7F;
      end
   end

   // State and registered display outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         dig_q   <= 3'd0;
         fd_q    <= 1'b0;
         pseg_q  <= 32'd0;
         pneg_q  <= 1'b0;
         aseg_q  <= 32'd0;
         aneg_q  <= 1'b0;
         an_q    <= 8'hFF;
         hex_q   <= 7'h7F;
         ovf_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         dig_q   <= dig_d;
         fd_q    <= fd_d;
         pseg_q  <= pseg_d;
         pneg_q  <= pneg_d;
         aseg_q  <= aseg_d;
         aneg_q  <= aneg_d;
         an_q    <= an_d;
         hex_q   <= hex_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.anodo      = an_q;
   assign bus.hex        = hex_q;
   assign bus.digito     = dig_q;
   assign bus.frame_done = fd_q;
   assign bus.ovf        = ovf_q;

endmodule
